mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two client ports (fetch, load/store) and the shared memory port.
// The master modport is the arbiter's view; slave is the clients/memory side.
interface mem_port_arbiter_if;
    logic        fetch_mem_read;
    logic [31:0] fetch_mem_address;
    logic [31:0] fetch_mem_rdata;
    logic        fetch_mem_resp;

    logic        ld_st_mem_read;
    logic        ld_st_mem_write;
    logic [31:0] ld_st_mem_address;
    logic [31:0] ld_st_mem_wdata;
    logic [31:0] ld_st_mem_rdata;
    logic        ld_st_mem_resp;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  fetch_mem_read, fetch_mem_address,
        output fetch_mem_rdata, fetch_mem_resp,
        input  ld_st_mem_read, ld_st_mem_write, ld_st_mem_address, ld_st_mem_wdata,
        output ld_st_mem_rdata, ld_st_mem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output fetch_mem_read, fetch_mem_address,
        input  fetch_mem_rdata, fetch_mem_resp,
        output ld_st_mem_read, ld_st_mem_write, ld_st_mem_address, ld_st_mem_wdata,
        input  ld_st_mem_rdata, ld_st_mem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client arbiter in front of a single-ported memory: load/store wins ties,
// but fetch is forced through after STARVE_LIMIT consecutive contested ld_st grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus,
    output logic                 busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LDST  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        mem_read_reg, mem_read_next;
    logic        mem_write_reg, mem_write_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    logic fetch_req;
    logic ldst_req;
    logic grant_fetch;
    logic grant_ldst;

    assign fetch_req = bus.fetch_mem_read;
    assign ldst_req  = bus.ld_st_mem_read | bus.ld_st_mem_write;

    always_comb begin
        state_next       = state_reg;
        starve_cnt_next  = starve_cnt_reg;
        mem_read_next    = mem_read_reg;
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;
        grant_fetch      = 1'b0;
        grant_ldst       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fetch_req && (!ldst_req || starve_cnt_reg == LIMIT))
                    grant_fetch = 1'b1;
                else if (ldst_req)
                    grant_ldst = 1'b1;
            end
            FETCH, LDST: begin
                if (bus.mem_resp) begin
                    state_next     = IDLE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (grant_fetch) begin
            state_next       = FETCH;
            starve_cnt_next  = 4'd0;
            mem_read_next    = 1'b1;
            mem_write_next   = 1'b0;
            mem_address_next = bus.fetch_mem_address;
            mem_wdata_next   = 32'd0;
        end

        // A write wins when the load/store port raises both read and write.
        if (grant_ldst) begin
            state_next       = LDST;
            if (fetch_req && starve_cnt_reg < LIMIT)
                starve_cnt_next = starve_cnt_reg + 4'd1;
            mem_write_next   = bus.ld_st_mem_write;
            mem_read_next    = bus.ld_st_mem_read & ~bus.ld_st_mem_write;
            mem_address_next = bus.ld_st_mem_address;
            mem_wdata_next   = bus.ld_st_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            starve_cnt_reg  <= 4'd0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= 32'd0;
            mem_wdata_reg   <= 32'd0;
        end else begin
            state_reg       <= state_next;
            starve_cnt_reg  <= starve_cnt_next;
            mem_read_reg    <= mem_read_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
        end
    end

    assign bus.mem_read        = mem_read_reg;
    assign bus.mem_write       = mem_write_reg;
    assign bus.mem_address     = mem_address_reg;
    assign bus.mem_wdata       = mem_wdata_reg;
    assign bus.fetch_mem_rdata = bus.mem_rdata;
    assign bus.ld_st_mem_rdata = bus.mem_rdata;
    assign bus.fetch_mem_resp  = bus.mem_resp & (state_reg == FETCH);
    assign bus.ld_st_mem_resp  = bus.mem_resp & (state_reg == LDST);
    assign busy                = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory requests are queued when
// client stimulus is driven and compared when the arbiter issues them.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    logic busy;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_fetch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic f, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_fetch = f; e.rd = r; e.wr = w; e.addr = a; e.wdata = d;
        sb.push_back(e);
    endtask

    // Waits for the grant, checks the latched request, optionally disturbs the
    // client inputs, then answers after lat busy cycles with rdata.
    task automatic do_txn(input int lat, input logic [31:0] rdata,
                          input bit mutate, input bit drop_mid, input bit drop_end);
        exp_t e;
        int   waited;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!busy && waited < 20);
        chk("grant_latency", waited, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk("mem_read", bus.mem_read, e.rd);
        chk("mem_write", bus.mem_write, e.wr);
        chk("mem_address", bus.mem_address, e.addr);
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        if (e.is_fetch) chk("starve_after_fetch", dut.starve_cnt_reg, 0);
        if (mutate) begin
            bus.fetch_mem_address = bus.fetch_mem_address + 32'h100;
            bus.ld_st_mem_address = bus.ld_st_mem_address + 32'h100;
            bus.ld_st_mem_wdata   = ~bus.ld_st_mem_wdata;
        end
        if (drop_mid) begin
            bus.fetch_mem_read  = 0;
            bus.ld_st_mem_read  = 0;
            bus.ld_st_mem_write = 0;
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("hold_address", bus.mem_address, e.addr);
            chk("hold_wdata", bus.mem_wdata, e.wdata);
            chk("hold_read", bus.mem_read, e.rd);
            chk("hold_busy", busy, 1);
            chk("early_resp", {bus.fetch_mem_resp, bus.ld_st_mem_resp}, 0);
        end
        bus.mem_rdata = rdata;
        bus.mem_resp  = 1;
        #1;
        chk("fetch_resp", bus.fetch_mem_resp, e.is_fetch);
        chk("ld_st_resp", bus.ld_st_mem_resp, !e.is_fetch);
        chk("fetch_rdata", bus.fetch_mem_rdata, rdata);
        chk("ld_st_rdata", bus.ld_st_mem_rdata, rdata);
        txn_no++;
        $display("txn %0d: %s rd=%0b wr=%0b addr=%h wdata=%h rdata=%h",
                 txn_no, e.is_fetch ? "FETCH" : "LDST ", e.rd, e.wr, e.addr, e.wdata, rdata);
        @(posedge clk);
        #1;
        bus.mem_resp = 0;
        if (drop_end) begin
            bus.fetch_mem_read  = 0;
            bus.ld_st_mem_read  = 0;
            bus.ld_st_mem_write = 0;
        end
        chk("idle_busy", busy, 0);
        chk("idle_mem_read", bus.mem_read, 0);
        chk("idle_mem_write", bus.mem_write, 0);
    endtask

    initial begin
        clk = 0;
        rst = 0;
        bus.fetch_mem_read    = 0;
        bus.fetch_mem_address = 0;
        bus.ld_st_mem_read    = 0;
        bus.ld_st_mem_write   = 0;
        bus.ld_st_mem_address = 0;
        bus.ld_st_mem_wdata   = 0;
        bus.mem_rdata         = 0;
        bus.mem_resp          = 0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_starve", dut.starve_cnt_reg, 0);
        rst = 1;

        // Fetch-only read, answered on the third busy cycle
        bus.fetch_mem_read = 1; bus.fetch_mem_address = 32'h60;
        push(1, 1, 0, 32'h60, 32'h0);
        do_txn(3, 32'h00000013, 0, 0, 1);

        // Store
        bus.ld_st_mem_write = 1; bus.ld_st_mem_address = 32'h100; bus.ld_st_mem_wdata = 32'hDEADBEEF;
        push(0, 0, 1, 32'h100, 32'hDEADBEEF);
        do_txn(2, 32'h0, 0, 0, 1);

        // Address changes 0x100 -> 0x200 mid-transaction must not disturb the latched request
        bus.ld_st_mem_read = 1; bus.ld_st_mem_address = 32'h100; bus.ld_st_mem_wdata = 32'h0;
        push(0, 1, 0, 32'h100, 32'h0);
        do_txn(4, 32'hCAFEF00D, 1, 0, 1);

        // Read and write both high: write only
        bus.ld_st_mem_read = 1; bus.ld_st_mem_write = 1;
        bus.ld_st_mem_address = 32'h300; bus.ld_st_mem_wdata = 32'h12345678;
        push(0, 0, 1, 32'h300, 32'h12345678);
        do_txn(1, 32'h0, 0, 0, 1);

        // Stray memory response while idle
        bus.mem_resp = 1;
        #1;
        chk("stray_fetch_resp", bus.fetch_mem_resp, 0);
        chk("stray_ld_st_resp", bus.ld_st_mem_resp, 0);
        tick();
        chk("stray_busy", busy, 0);
        bus.mem_resp = 0;

        // Fetch drops its request mid-transaction; response still delivered
        bus.fetch_mem_read = 1; bus.fetch_mem_address = 32'h80;
        push(1, 1, 0, 32'h80, 32'h0);
        do_txn(3, 32'h55AA55AA, 0, 1, 1);

        // Contention with a 1-cycle memory: four LDST grants, then FETCH, twice over
        bus.fetch_mem_read = 1; bus.fetch_mem_address = 32'h400;
        bus.ld_st_mem_read = 1; bus.ld_st_mem_write = 0;
        bus.ld_st_mem_address = 32'h500; bus.ld_st_mem_wdata = 32'hA5A5A5A5;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(0, 1, 0, 32'h500, 32'hA5A5A5A5);
            push(1, 1, 0, 32'h400, 32'h0);
        end
        for (int t = 0; t < 10; t++) do_txn(1, 32'h1000 + t, 0, 0, t == 9);
        chk("sb_drained", sb.size(), 0);

        // Reset in the middle of a load/store transaction
        bus.ld_st_mem_read = 1; bus.ld_st_mem_address = 32'h700; bus.ld_st_mem_wdata = 32'h77;
        tick();
        chk("mid_grant_busy", busy, 1);
        chk("mid_grant_addr", bus.mem_address, 32'h700);
        #3;
        rst = 0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_mem_read", bus.mem_read, 0);
        chk("async_mem_address", bus.mem_address, 0);
        chk("async_mem_wdata", bus.mem_wdata, 0);
        bus.mem_resp = 1;
        #1;
        chk("rst_ld_st_resp", bus.ld_st_mem_resp, 0);
        chk("rst_fetch_resp", bus.fetch_mem_resp, 0);
        bus.ld_st_mem_read = 0;
        tick();
        rst = 1;
        tick();
        chk("late_ld_st_resp", bus.ld_st_mem_resp, 0);
        chk("late_busy", busy, 0);
        bus.mem_resp = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
